// File: rtl/cat_recognizer_pkg.sv
// Shared definitions for the cat_recognizer front end: loader FSM states,
// control register command values and the default control register address.
package cat_recognizer_pkg;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_W_SETUP,
      ST_W_ACCESS,
      ST_W_HOLD,
      ST_S_SETUP,
      ST_S_ACCESS,
      ST_WAIT,
      ST_C_SETUP,
      ST_C_ACCESS
   } loader_state_t;

   localparam int CTRL_START        = 1;
   localparam int CTRL_STOP         = 0;
   localparam int CTRL_ADDR_DEFAULT = 0;

endpackage

// File: rtl/apb_write_port.sv
// APB write sequencer: while req is high it alternates SETUP and ACCESS.
// Address/data are registered on ld and held between transfers.
module apb_write_port #(
   parameter int ADDR_W = 13,
   parameter int DATA_W = 24
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req,
   input  logic              ld,
   input  logic [ADDR_W-1:0] ld_addr,
   input  logic [DATA_W-1:0] ld_data,
   output logic              psel,
   output logic              penable,
   output logic              pwrite,
   output logic [ADDR_W-1:0] paddr,
   output logic [DATA_W-1:0] pwdata,
   output logic              done
);

   logic access_reg;

   // access_reg marks the second cycle of every back-to-back request pair
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         access_reg <= 1'b0;
         paddr      <= '0;
         pwdata     <= '0;
      end else begin
         access_reg <= req & ~access_reg;
         if (ld) begin
            paddr  <= ld_addr;
            pwdata <= ld_data;
         end
      end
   end

   assign psel    = req;
   assign pwrite  = req;
   assign penable = req & access_reg;
   assign done    = req & access_reg;

endmodule

// File: rtl/apb_frame_loader.sv
// Streams one frame into cat_recognizer over APB, starts it, captures the
// decision, then stops it. Define FRAME_CHECK_EN to enable s_last checking.
module apb_frame_loader
   import cat_recognizer_pkg::*;
#(
   parameter int Amba_Word       = 24,
   parameter int Amba_Addr_Depth = 13,
   parameter int Num_Words       = 4095,
   parameter int Ctrl_Addr       = CTRL_ADDR_DEFAULT,
   parameter int Calc_Cycles     = 4104
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       s_valid,
   output logic                       s_ready,
   input  logic [Amba_Word-1:0]       s_data,
   input  logic                       s_last,
   output logic                       PSEL,
   output logic                       PENABLE,
   output logic                       PWRITE,
   output logic [Amba_Addr_Depth-1:0] PADDR,
   output logic [Amba_Word-1:0]       PWDATA,
   input  logic                       CatRecOut,
   output logic                       busy,
   output logic                       result_valid,
   output logic                       result,
   output logic                       err
);

   localparam int WAIT_W = $clog2(Calc_Cycles + 1);
   localparam logic [Amba_Addr_Depth-1:0] NUM_W     = Amba_Addr_Depth'(Num_Words);
   localparam logic [Amba_Addr_Depth-1:0] CTRL_A    = Amba_Addr_Depth'(Ctrl_Addr);
   localparam logic [Amba_Addr_Depth-1:0] ADDR_ONE  = Amba_Addr_Depth'(1);
   localparam logic [WAIT_W-1:0]          CALC_LOAD = WAIT_W'(Calc_Cycles - 1);

   loader_state_t              state_reg, state_next;
   logic [Amba_Addr_Depth-1:0] word_cnt_reg, word_cnt_next;
   logic [WAIT_W-1:0]          wait_cnt_reg, wait_cnt_next;
   logic                       result_reg, result_next;
   logic                       result_valid_reg, result_valid_next;
   logic                       last_reg;
   logic                       take;

   logic                       port_req;
   logic                       port_ld;
   logic [Amba_Addr_Depth-1:0] port_addr;
   logic [Amba_Word-1:0]       port_data;
   logic                       port_done;

`ifdef FRAME_CHECK_EN
   localparam logic FRAME_CHECK = 1'b1;

   // s_last travels with its word so it can be judged in that word's ACCESS
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         last_reg <= 1'b0;
      end else if (take) begin
         last_reg <= s_last;
      end
   end
`else
   localparam logic FRAME_CHECK = 1'b0;
   logic unused_frame_inputs;
   assign unused_frame_inputs = s_last ^ take;
   assign last_reg = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg        <= ST_IDLE;
         word_cnt_reg     <= '0;
         wait_cnt_reg     <= '0;
         result_reg       <= 1'b0;
         result_valid_reg <= 1'b0;
      end else begin
         state_reg        <= state_next;
         word_cnt_reg     <= word_cnt_next;
         wait_cnt_reg     <= wait_cnt_next;
         result_reg       <= result_next;
         result_valid_reg <= result_valid_next;
      end
   end

   always_comb begin
      state_next        = state_reg;
      word_cnt_next     = word_cnt_reg;
      wait_cnt_next     = wait_cnt_reg;
      result_next       = result_reg;
      result_valid_next = 1'b0;
      port_req          = 1'b0;
      port_ld           = 1'b0;
      port_addr         = '0;
      port_data         = '0;
      s_ready           = 1'b0;
      take              = 1'b0;
      err               = 1'b0;

      case (state_reg)
         ST_IDLE: begin
            s_ready = 1'b1;
            if (s_valid) begin
               take          = 1'b1;
               port_ld       = 1'b1;
               port_addr     = ADDR_ONE;
               port_data     = s_data;
               word_cnt_next = ADDR_ONE;
               state_next    = ST_W_SETUP;
            end
         end

         ST_W_SETUP: begin
            port_req   = 1'b1;
            state_next = ST_W_ACCESS;
         end

         // port_done is high only in the ACCESS cycle, never in W_HOLD
         ST_W_ACCESS, ST_W_HOLD: begin
            port_req = (state_reg == ST_W_ACCESS);
            if (port_done && word_cnt_reg == NUM_W) begin
               err           = FRAME_CHECK & ~last_reg;
               port_ld       = 1'b1;
               port_addr     = CTRL_A;
               port_data     = Amba_Word'(CTRL_START);
               wait_cnt_next = CALC_LOAD;
               state_next    = ST_S_SETUP;
            end else if (port_done && last_reg) begin
               err        = 1'b1;
               state_next = ST_IDLE;
            end else begin
               s_ready = 1'b1;
               if (s_valid) begin
                  take          = 1'b1;
                  port_ld       = 1'b1;
                  port_addr     = word_cnt_reg + ADDR_ONE;
                  port_data     = s_data;
                  word_cnt_next = word_cnt_reg + ADDR_ONE;
                  state_next    = ST_W_SETUP;
               end else begin
                  state_next = ST_W_HOLD;
               end
            end
         end

         ST_S_SETUP: begin
            port_req   = 1'b1;
            state_next = ST_S_ACCESS;
         end

         // The count runs from S_ACCESS so the strobe lands Calc_Cycles later
         ST_S_ACCESS, ST_WAIT: begin
            port_req = (state_reg == ST_S_ACCESS);
            if (wait_cnt_reg == '0) begin
               result_next       = CatRecOut;
               result_valid_next = 1'b1;
               port_ld           = 1'b1;
               port_addr         = CTRL_A;
               port_data         = Amba_Word'(CTRL_STOP);
               state_next        = ST_C_SETUP;
            end else begin
               wait_cnt_next = wait_cnt_reg - WAIT_W'(1);
               state_next    = ST_WAIT;
            end
         end

         ST_C_SETUP: begin
            port_req   = 1'b1;
            state_next = ST_C_ACCESS;
         end

         ST_C_ACCESS: begin
            port_req = 1'b1;
            if (port_done) begin
               state_next = ST_IDLE;
            end
         end

         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   apb_write_port #(
      .ADDR_W (Amba_Addr_Depth),
      .DATA_W (Amba_Word)
   ) u_write_port (
      .clk     (clk),
      .rst     (rst),
      .req     (port_req),
      .ld      (port_ld),
      .ld_addr (port_addr),
      .ld_data (port_data),
      .psel    (PSEL),
      .penable (PENABLE),
      .pwrite  (PWRITE),
      .paddr   (PADDR),
      .pwdata  (PWDATA),
      .done    (port_done)
   );

   assign busy         = (state_reg != ST_IDLE);
   assign result       = result_reg;
   assign result_valid = result_valid_reg;

endmodule
